aes_shift_mix_addkey: RTL and testbench

- Round datapath stage directly downstream of the SubBytes stage in the AES-128 encryption core.
- Takes the substituted 128-bit state and applies ShiftRows, then MixColumns (skipped on the final round), then AddRoundKey.
- Tracks the round number internally and flags the final round.
- Valid/ready on both sides with a 2-entry skid buffer, so it can be back-pressured without throughput loss.

---
 rtl/aes_shift_mix_addkey.sv | 183 ++++++++++++++++++
 tb/tb_aes_shift_mix_addkey.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_shift_mix_addkey.sv
// ============================================================================
// Module      : aes_shift_mix_addkey
// Description : AES-128 round stage after SubBytes: ShiftRows, MixColumns
//               (bypassed on round NR), AddRoundKey, with a valid/ready skid
//               buffer. Optional macro AES_SMA_PIPE2_EN adds a register stage
//               between MixColumns and AddRoundKey.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_shift_mix_addkey #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [127:0]    in_state,
    input  logic [127:0]    in_round_key,
    input  logic            in_first,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [127:0]    out_state,
    output logic [RW-1:0]   out_round,
    output logic            out_last
);

    typedef struct packed {
        logic [127:0]  state;
        logic [RW-1:0] round;
        logic          last;
    } beat_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    logic [RW-1:0] cnt;
    logic [RW-1:0] rnd;
    logic          final_rnd;
    logic [127:0]  mixed;
    logic          accept;

    always_comb begin
        rnd       = in_first ? RW'(1) : cnt;
        final_rnd = (rnd == RW'(NR));
        mixed     = final_rnd ? shift_rows(in_state) : mix_columns(shift_rows(in_state));
    end

    assign accept = in_valid && in_ready;

    // push/push_beat: the beat entering the output queue this cycle.
    // stage_busy: a beat will occupy the mid pipeline register next cycle.
    logic  push;
    beat_t push_beat;
    logic  stage_busy;

`ifdef AES_SMA_PIPE2_EN
    localparam int SKD = 2;

    logic          p_valid;
    logic [127:0]  p_state;
    logic [127:0]  p_key;
    logic [RW-1:0] p_round;
    logic          p_last;

    always_ff @(posedge clk) begin
        if (reset) p_valid <= 1'b0;
        else       p_valid <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            p_state <= mixed;
            p_key   <= in_round_key;
            p_round <= rnd;
            p_last  <= final_rnd;
        end
    end

    assign push       = p_valid;
    assign push_beat  = {p_state ^ p_key, p_round, p_last};
    assign stage_busy = accept;
`else
    localparam int SKD = 1;

    assign push       = accept;
    assign push_beat  = {mixed ^ in_round_key, rnd, final_rnd};
    assign stage_busy = 1'b0;
`endif

    beat_t      or_q, or_n;
    logic       ov_n;
    beat_t      sk_q [SKD];
    beat_t      sk_n [SKD];
    logic [1:0] skc, skc_n;
    int         occ;

    always_comb begin
        ov_n  = out_valid;
        or_n  = or_q;
        sk_n  = sk_q;
        skc_n = skc;
        if (!out_valid || out_ready) begin
            if (skc != 2'd0) begin
                // Oldest skid entry moves to the output; a new beat refills the tail.
                or_n = sk_q[0];
                ov_n = 1'b1;
                for (int i = 0; i < SKD-1; i++) sk_n[i] = sk_q[i+1];
                if (push) begin
                    for (int i = 0; i < SKD; i++)
                        if (2'(i) == skc - 2'd1) sk_n[i] = push_beat;
                end else begin
                    skc_n = skc - 2'd1;
                end
            end else begin
                ov_n = push;
                if (push) or_n = push_beat;
            end
        end else if (push) begin
            for (int i = 0; i < SKD; i++)
                if (2'(i) == skc) sk_n[i] = push_beat;
            skc_n = skc + 2'd1;
        end
        occ = int'(skc_n) + (stage_busy ? 1 : 0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            or_q      <= '0;
            skc       <= 2'd0;
            in_ready  <= 1'b0;
            cnt       <= RW'(1);
        end else begin
            out_valid <= ov_n;
            or_q      <= or_n;
            skc       <= skc_n;
            in_ready  <= (occ < SKD);
            if (accept) cnt <= final_rnd ? RW'(1) : rnd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        sk_q <= sk_n;
    end

    assign out_state = or_q.state;
    assign out_round = or_q.round;
    assign out_last  = or_q.last;

endmodule

`default_nettype wire

// File: tb/tb_aes_shift_mix_addkey.sv
// ============================================================================
// Module      : tb_aes_shift_mix_addkey
// Description : Self-checking bench for aes_shift_mix_addkey: byte-level AES
//               round model with scoreboard, plus directed FIPS-197 vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_shift_mix_addkey;

    localparam int NR = 10;
    localparam int RW = 4;
`ifdef AES_SMA_PIPE2_EN
    localparam int LAT = 2;
    localparam int CAP = 3;
`else
    localparam int LAT = 1;
    localparam int CAP = 2;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  in_state;
    logic [127:0]  in_round_key;
    logic          in_first;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_state;
    logic [RW-1:0] out_round;
    logic          out_last;

    aes_shift_mix_addkey #(.NR(NR), .RW(RW)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_state     (in_state),
        .in_round_key (in_round_key),
        .in_first     (in_first),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_state    (out_state),
        .out_round    (out_round),
        .out_last     (out_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // GF(2^8) product by shift-and-add over the AES polynomial.
    function automatic logic [7:0] gmul(input logic [7:0] a, input int m);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (m[k]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
        end
        return p;
    endfunction

    function automatic logic [127:0] model_round(input logic [127:0] s, input logic [127:0] key,
                                                 input bit fin);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   m [16];
        logic [127:0] o;
        int           base [4] = '{2, 3, 1, 1};
        for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                m[4*c+r] = 8'h00;
                for (int k = 0; k < 4; k++)
                    m[4*c+r] = m[4*c+r] ^ gmul(t[4*c+k], base[(k-r+4)%4]);
            end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = (fin ? t[i] : m[i]) ^ key[127-8*i -: 8];
        return o;
    endfunction

    typedef struct {
        logic [127:0] st;
        int           rnd;
    } exp_t;

    exp_t exp_q[$];
    int   seen_q[$];
    int   mcnt = 1;

    // Reference: capture every accepted beat and compute its expected result.
    initial forever begin
        int   r;
        exp_t e;
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            mcnt = 1;
        end else if (in_valid && in_ready) begin
            r     = in_first ? 1 : mcnt;
            e.st  = model_round(in_state, in_round_key, r == NR);
            e.rnd = r;
            exp_q.push_back(e);
            mcnt  = (r == NR) ? 1 : r + 1;
        end
    end

    // Compare process: transfers against the model, stalled outputs against themselves.
    initial forever begin
        bit            stalled = 0;
        logic [127:0]  h_state;
        logic [RW-1:0] h_round;
        logic          h_last;
        exp_t          e;
        @(negedge clk);
        if (reset) begin
            stalled = 0;
            continue;
        end
        if (stalled) begin
            chk("stall_valid", 128'(out_valid), 128'(1));
            chk("stall_state", out_state, h_state);
            chk("stall_round_last", 128'({out_round, out_last}), 128'({h_round, h_last}));
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 128'(out_round), 128'(0));
            end else begin
                e = exp_q.pop_front();
                chk("sb_state", out_state, e.st);
                chk("sb_round", 128'(out_round), 128'(e.rnd));
                chk("sb_last", 128'(out_last), 128'(e.rnd == NR));
            end
            seen_q.push_back(int'(out_round));
        end
        stalled = out_valid && !out_ready;
        h_state = out_state;
        h_round = out_round;
        h_last  = out_last;
    end

    task automatic send(input logic [127:0] st, input logic [127:0] k, input logic first);
        int t = 0;
        in_valid     = 1'b1;
        in_state     = st;
        in_round_key = k;
        in_first     = first;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t == 50) chk("send_timeout", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [127:0] st, input int rnd,
                              input logic last);
        int l = 1;
        while (!out_valid && l < 20) begin
            @(posedge clk); #1;
            l++;
        end
        chk({name, "_latency"}, 128'(l), 128'(LAT));
        chk({name, "_state"}, out_state, st);
        chk({name, "_round"}, 128'(out_round), 128'(rnd));
        chk({name, "_last"}, 128'(out_last), 128'(last));
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        bit rdy;
        reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b1;
        in_state = '0; in_round_key = '0;

        // Model pinned to hand-computed vectors.
        chk("model_fips", model_round(128'hd42711aee0bf98f1b8b45de51e415230,
                                      128'ha0fafe1788542cb123a339392a6c7605, 1'b0),
            128'ha49c7ff2689f352b6b5bea43026a5049);
        chk("model_shift", model_round(128'h000102030405060708090a0b0c0d0e0f, '0, 1'b1),
            128'h00050a0f04090e03080d02070c01060b);
        chk("model_mix", model_round(128'hdb000000001300000000530000000045, '0, 1'b0),
            128'h8e4da1bc000000000000000000000000);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_state", out_state, 128'(0));
        chk("rst_round_last", 128'({out_round, out_last}), 128'(0));
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 128'(in_ready), 128'(1));

        send(128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605, 1'b1);
        expect_out("fips", 128'ha49c7ff2689f352b6b5bea43026a5049, 1, 1'b0);

        send(rnd128(), rnd128(), 1'b1);
        for (int i = 0; i < 8; i++) send(rnd128(), rnd128(), 1'b0);
        send(128'h000102030405060708090a0b0c0d0e0f, '0, 1'b0);
        expect_out("shiftrows", 128'h00050a0f04090e03080d02070c01060b, 10, 1'b1);

        send(128'hdb000000001300000000530000000045, '0, 1'b1);
        expect_out("mixcol", 128'h8e4da1bc000000000000000000000000, 1, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // Back-pressure: offer beats while downstream is stalled.
        out_ready = 1'b0;
        in_valid = 1'b1; in_first = 1'b0;
        in_state = rnd128(); in_round_key = rnd128();
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) begin
                acc++;
                in_state = rnd128(); in_round_key = rnd128();
                if (acc == CAP) chk("bp_ready_after_fill", 128'(in_ready), 128'(0));
            end
        end
        in_valid = 1'b0;
        chk("bp_accepted", 128'(acc), 128'(CAP));
        chk("bp_in_ready", 128'(in_ready), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("bp_drained", 128'(exp_q.size()), 128'(0));

        // Reset with output and skid registers occupied.
        out_ready = 1'b0;
        send(rnd128(), rnd128(), 1'b0);
        send(rnd128(), rnd128(), 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        chk("midrst_in_ready_after", 128'(in_ready), 128'(1));
        out_ready = 1'b1;

        // Wrap: 12 beats from a fresh counter.
        seen_q.delete();
        for (int i = 0; i < 12; i++) send(rnd128(), rnd128(), 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("wrap_count", 128'(seen_q.size()), 128'(12));
        for (int i = 0; i < 12 && i < seen_q.size(); i++)
            chk($sformatf("wrap_round_%0d", i), 128'(seen_q[i]), 128'((i % 10) + 1));

        send(rnd128(), rnd128(), 1'b0);
        send(rnd128(), rnd128(), 1'b1);
        expect_out("restart", model_round(in_state, in_round_key, 1'b0), 1, 1'b0);

        // Randomised traffic with random back-pressure.
        for (int i = 0; i < 600; i++) begin
            in_valid     = ($urandom % 4) != 0;
            in_first     = ($urandom % 16) == 0;
            in_state     = rnd128();
            in_round_key = rnd128();
            out_ready    = ($urandom % 4) != 0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("final_drained", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
